// File: rtl/iobuf_bank_turnaround_pkg.sv
// Shared types and constants for the turnaround I/O bank: FSM encoding, counter width, parameter limits.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package iobuf_bank_turnaround_pkg;

   localparam int TURN_CNT_W = 4;
   localparam int TURN_MAX   = 15;
   localparam int SYNC_MIN   = 2;
   localparam int SYNC_MAX   = 4;
   localparam int WIDTH_MAX  = 32;

   typedef enum logic [1:0] {
      ST_RX   = 2'd0,
      ST_TURN = 2'd1,
      ST_TX   = 2'd2
   } state_t;

   // Value loaded into the dead-time counter on leaving RX; the counter counts down to 0,
   // so N dead cycles need a load of N-1.
   function automatic logic [TURN_CNT_W-1:0] turn_load(input int turns);
      if (turns <= 0) return '0;
      return TURN_CNT_W'(turns - 1);
   endfunction

endpackage

// File: rtl/iobuf_bank_turnaround_sync_edge.sv
// Pad readback synchroniser with per-bit rise/fall pulse generation.
// Latency: in_data SYNC_STAGES clks after a pad change, in_rise/in_fall one clk later.
// Backpressure: none; samples every clock.
module iobuf_sync_edge
   import iobuf_bank_turnaround_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] pad,
   output logic [WIDTH-1:0] in_data,
   output logic [WIDTH-1:0] in_rise,
   output logic [WIDTH-1:0] in_fall
);

   if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
      $error("iobuf_sync_edge: SYNC_STAGES=%0d outside 2..4", SYNC_STAGES);
   end

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0]                  hist_q;
   logic [WIDTH-1:0]                  rise_q;
   logic [WIDTH-1:0]                  fall_q;

   // Shift the raw pad value through the synchroniser chain; index 0 is the metastable stage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
      end
   end

   // Keep one cycle of history and register the per-bit edge pulses against it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist_q <= '0;
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         hist_q <= sync_q[SYNC_STAGES-1];
         rise_q <= sync_q[SYNC_STAGES-1] & ~hist_q;
         fall_q <= ~sync_q[SYNC_STAGES-1] & hist_q;
      end
   end

   assign in_data = sync_q[SYNC_STAGES-1];
   assign in_rise = rise_q;
   assign in_fall = fall_q;

endmodule

// File: rtl/iobuf_bank_turnaround.sv
// Bank of bidirectional pads with registered data/enable and a dead-time turnaround FSM.
// Latency: pads driven TURN_CYCLES+1 clks after out_req is first sampled; data 1 clk behind out_data.
// Backpressure: none; busy flags the dead-time window, out_req low releases the pads next edge.
module iobuf_bank_turnaround
   import iobuf_bank_turnaround_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter int               SYNC_STAGES = 2,
   parameter int               TURN_CYCLES = 1,
   parameter logic [WIDTH-1:0] INIT_OUT    = '0
) (
   input  logic             clk,
   input  logic             reset,
   inout  wire  [WIDTH-1:0] io,
   input  logic [WIDTH-1:0] out_data,
   input  logic             out_req,
   output logic             drive_en,
   output logic             busy,
   output logic [WIDTH-1:0] in_data,
   output logic [WIDTH-1:0] in_rise,
   output logic [WIDTH-1:0] in_fall
);

   if (TURN_CYCLES < 0 || TURN_CYCLES > TURN_MAX) begin : g_bad_turn
      $error("iobuf_bank_turnaround: TURN_CYCLES=%0d exceeds 4-bit counter range 0..15", TURN_CYCLES);
   end
   if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("iobuf_bank_turnaround: WIDTH=%0d outside 1..32", WIDTH);
   end

   localparam logic [TURN_CNT_W-1:0] TURN_LOAD = turn_load(TURN_CYCLES);

   state_t                 state_q, state_d;
   logic [TURN_CNT_W-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0]       out_reg;

   // State and dead-time counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_RX;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic: RX waits for a request, TURN burns dead cycles, TX drives until released.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_RX: begin
            if (out_req) begin
               if (TURN_CYCLES == 0) begin
                  state_d = ST_TX;
               end else begin
                  state_d = ST_TURN;
                  cnt_d   = TURN_LOAD;
               end
            end
         end
         ST_TURN: begin
            if (!out_req) begin
               state_d = ST_RX;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               state_d = ST_TX;
            end else begin
               cnt_d = cnt_q - TURN_CNT_W'(1);
            end
         end
         ST_TX: begin
            if (!out_req) state_d = ST_RX;
         end
         default: begin
            state_d = ST_RX;
            cnt_d   = '0;
         end
      endcase
   end

   // Output data register loads whenever a request is present, so TX starts with fresh data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_reg <= INIT_OUT;
      end else if (out_req) begin
         out_reg <= out_data;
      end
   end

   // Enable is decoded straight from the state flop so an async reset releases the pads at once.
   assign drive_en = (state_q == ST_TX);
   assign busy     = (state_q == ST_TURN);
   assign io       = drive_en ? out_reg : {WIDTH{1'bz}};

   iobuf_sync_edge #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_edge (
      .clk     (clk),
      .reset   (reset),
      .pad     (io),
      .in_data (in_data),
      .in_rise (in_rise),
      .in_fall (in_fall)
   );

endmodule
